// File: rtl/uart_frame_sched.sv
`default_nettype none
// ============================================================================
// uart_frame_sched : sequences header, pixel stream and checksum into uart_send
// Revision 1.0
// ============================================================================
module uart_frame_sched #(
    parameter int unsigned IMG_W       = 64,
    parameter int unsigned IMG_H       = 64,
    parameter logic [7:0]  SYNC0       = 8'hAA,
    parameter logic [7:0]  SYNC1       = 8'h55,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       pix_valid_i,
    input  logic [7:0] pix_data_i,
    output logic       pix_ready_o,
    input  logic       tx_busy_i,
    output logic       tx_en_o,
    output logic [7:0] tx_data_o,
    output logic       frame_busy_o,
    output logic       frame_done_o,
    output logic       err_timeout_o
);
    localparam int unsigned    NPIX    = IMG_W * IMG_H;
    localparam int             PCW     = $clog2(NPIX + 1);
    localparam int             TCW     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [PCW-1:0] NPIX_C  = PCW'(NPIX);
    localparam logic [TCW-1:0] TO_LAST = TCW'(ACK_TIMEOUT - 1);
    localparam logic [15:0]    W16     = 16'(IMG_W);
    localparam logic [15:0]    H16     = 16'(IMG_H);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_WAIT_HI, S_WAIT_LO, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SRC_HDR, SRC_PIX, SRC_CK
    } src_t;

    state_t         state_q, state_d;
    src_t           src_q, src_d;
    logic [2:0]     hdr_q, hdr_d;
    logic [PCW-1:0] pix_cnt_q;
    logic [TCW-1:0] to_cnt_q;
    logic [7:0]     cksum_q, pix_q, tx_data_q, hdr_byte, load_byte;
    logic           tx_en_q, err_q;
    logic           accept, xfer, timeout;

    assign accept  = (state_q == S_IDLE) && start_i;
    assign xfer    = (state_q == S_FETCH) && pix_valid_i;
    assign timeout = (state_q == S_WAIT_HI) && !tx_busy_i && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            src_q   <= SRC_HDR;
            hdr_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            hdr_q   <= hdr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        hdr_d   = hdr_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    src_d   = SRC_HDR;
                    hdr_d   = 3'd0;
                end
            end
            S_FETCH:   if (pix_valid_i) state_d = S_LOAD;
            S_LOAD:    state_d = S_WAIT_HI;
            S_WAIT_HI: begin
                if (tx_busy_i)    state_d = S_WAIT_LO;
                else if (timeout) state_d = S_IDLE;
            end
            S_WAIT_LO: begin
                if (!tx_busy_i) begin
                    if (src_q == SRC_HDR && hdr_q < 3'd5) begin
                        hdr_d   = hdr_q + 3'd1;
                        state_d = S_LOAD;
                    end else if (pix_cnt_q != NPIX_C) begin
                        src_d   = SRC_PIX;
                        state_d = S_FETCH;
                    end else if (src_q != SRC_CK) begin
                        src_d   = SRC_CK;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (hdr_q)
            3'd1:    hdr_byte = SYNC1;
            3'd2:    hdr_byte = W16[15:8];
            3'd3:    hdr_byte = W16[7:0];
            3'd4:    hdr_byte = H16[15:8];
            3'd5:    hdr_byte = H16[7:0];
            default: hdr_byte = SYNC0;
        endcase
        case (src_q)
            SRC_PIX: load_byte = pix_q;
            SRC_CK:  load_byte = cksum_q;
            default: load_byte = hdr_byte;
        endcase
    end

    // tx_data is only written on the LOAD edge so it stays put for the whole byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_q <= '0;
            to_cnt_q  <= '0;
            cksum_q   <= 8'h00;
            pix_q     <= 8'h00;
            tx_data_q <= 8'h00;
            tx_en_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            tx_en_q <= (state_q == S_LOAD);
            if (accept) begin
                pix_cnt_q <= '0;
                cksum_q   <= 8'h00;
                err_q     <= 1'b0;
            end
            if (xfer) begin
                pix_q     <= pix_data_i;
                cksum_q   <= cksum_q + pix_data_i;
                pix_cnt_q <= pix_cnt_q + PCW'(1);
            end
            if (timeout) err_q <= 1'b1;
            if (state_q == S_LOAD) begin
                tx_data_q <= load_byte;
                to_cnt_q  <= '0;
            end else if (state_q == S_WAIT_HI && !tx_busy_i) begin
                to_cnt_q  <= to_cnt_q + TCW'(1);
            end
        end
    end

    assign pix_ready_o   = (state_q == S_FETCH);
    assign tx_en_o       = tx_en_q;
    assign tx_data_o     = tx_data_q;
    assign frame_busy_o  = (state_q != S_IDLE);
    assign frame_done_o  = (state_q == S_DONE);
    assign err_timeout_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_sched.sv
`default_nettype none
// ============================================================================
// tb_uart_frame_sched : randomized self-checking bench for uart_frame_sched
// Revision 1.0
// ============================================================================
module tb_uart_frame_sched;
    localparam int         W    = 2;
    localparam int         H    = 2;
    localparam int         NPIX = W * H;
    localparam int         TO   = 16;
    localparam logic [7:0] S0   = 8'hAA;
    localparam logic [7:0] S1   = 8'h55;

    logic       clk = 1'b0;
    logic       rst_n, start, pix_valid, pix_ready;
    logic       tx_busy = 1'b0;
    logic       tx_en, frame_busy, frame_done, err_timeout;
    logic [7:0] pix_data, tx_data;

    uart_frame_sched #(
        .IMG_W(W), .IMG_H(H), .SYNC0(S0), .SYNC1(S1), .ACK_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start),
        .pix_valid_i(pix_valid), .pix_data_i(pix_data), .pix_ready_o(pix_ready),
        .tx_busy_i(tx_busy), .tx_en_o(tx_en), .tx_data_o(tx_data),
        .frame_busy_o(frame_busy), .frame_done_o(frame_done),
        .err_timeout_o(err_timeout)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // uart_send stand-in: busy rises 3 cycles after tx_en and holds for 20
    int bm_pend = 0, bm_hold = 0;
    bit bm_respond = 1'b1, bm_kill = 1'b0;
    always @(posedge clk) begin
        if (bm_kill) begin
            bm_pend <= 0; bm_hold <= 0; tx_busy <= 1'b0;
        end else if (tx_en && bm_respond) begin
            bm_pend <= 3;
        end else if (bm_pend > 0) begin
            bm_pend <= bm_pend - 1;
            if (bm_pend == 1) begin tx_busy <= 1'b1; bm_hold <= 20; end
        end else if (bm_hold > 0) begin
            bm_hold <= bm_hold - 1;
            if (bm_hold == 1) tx_busy <= 1'b0;
        end
    end

    // pixel source: random valid gaps, optional 50-cycle stall at a pixel index
    logic [7:0] pixq[$];
    bit pend = 0;
    int nsent = 0, valid_pct = 100, stall_at = -1, stall_left = 0, stall_bad = 0;
    bit stall_done = 0;
    initial begin
        pix_valid = 1'b0; pix_data = 8'h00;
        forever begin
            @(negedge clk);
            if (pend) begin void'(pixq.pop_front()); nsent++; pend = 0; end
            if (!stall_done && nsent == stall_at && pix_ready) begin
                stall_done = 1; stall_left = 50;
            end
            if (stall_left > 0) begin
                stall_left--;
                pix_valid = 1'b0;
                if (!pix_ready || tx_en) stall_bad++;
            end else if (pixq.size() > 0 && $urandom_range(99) < valid_pct) begin
                pix_valid = 1'b1; pix_data = pixq[0];
            end else begin
                pix_valid = 1'b0; pix_data = 8'($urandom);
            end
            pend = pix_valid && pix_ready;
        end
    end

    // byte monitor
    logic [7:0] cap[$];
    logic [7:0] last_data = 8'h00;
    bit prev_en = 0;
    int ndone = 0, en_bad = 0, data_bad = 0;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_en = 0; last_data = 8'h00;
        end else begin
            if (tx_en) begin
                cap.push_back(tx_data);
                last_data = tx_data;
                if (prev_en) en_bad++;
            end else if (tx_data !== last_data) begin
                data_bad++;
            end
            if (frame_done) ndone++;
            prev_en = tx_en;
        end
    end

    logic [7:0] fpix[NPIX];
    logic [7:0] expq[$];

    task automatic build_exp();
        int sum = 0;
        expq.delete();
        expq.push_back(S0); expq.push_back(S1);
        expq.push_back(8'(W >> 8)); expq.push_back(8'(W));
        expq.push_back(8'(H >> 8)); expq.push_back(8'(H));
        for (int i = 0; i < NPIX; i++) begin
            expq.push_back(fpix[i]);
            sum += int'(fpix[i]);
        end
        expq.push_back(8'(sum % 256));
    endtask

    task automatic run_frame(input string tag, input int vpct, input int stall, input bit start_mid);
        bit got = 0, mid_done = 0;
        cap.delete(); ndone = 0; nsent = 0;
        stall_at = stall; stall_done = 0; valid_pct = vpct;
        pixq.delete();
        for (int i = 0; i < NPIX; i++) pixq.push_back(fpix[i]);
        build_exp();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, "_errclr"}, 32'(err_timeout), 0);
        for (int c = 0; c < 4000 && !got; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (start_mid && !mid_done && pix_ready) begin start = 1'b1; mid_done = 1; end
            if (ndone > 0) got = 1;
        end
        start = 1'b0;
        check({tag, "_finish"}, 32'(got), 1);
        repeat (40) @(negedge clk);
        check({tag, "_ndone"}, ndone, 1);
        check({tag, "_nbytes"}, cap.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            check($sformatf("%s_b%0d", tag, i),
                  (i < cap.size()) ? 32'(cap[i]) : 32'h100, 32'(expq[i]));
        check({tag, "_err"}, 32'(err_timeout), 0);
        check({tag, "_idle"}, 32'(frame_busy), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_txen"}, 32'(tx_en), 0);
        check({tag, "_txdata"}, 32'(tx_data), 0);
        check({tag, "_busy"}, 32'(frame_busy), 0);
        check({tag, "_done"}, 32'(frame_done), 0);
        check({tag, "_rdy"}, 32'(pix_ready), 0);
        check({tag, "_err"}, 32'(err_timeout), 0);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("post_rst");

        fpix = '{8'h10, 8'h20, 8'h30, 8'h40};
        run_frame("basic", 100, -1, 0);

        fpix = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_frame("wrap", 100, -1, 0);

        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NPIX; i++) fpix[i] = 8'($urandom);
            run_frame($sformatf("rand%0d", f), 30 + int'($urandom_range(60)), -1, 0);
        end

        for (int i = 0; i < NPIX; i++) fpix[i] = 8'($urandom);
        run_frame("midstart", 60, -1, 1);

        for (int i = 0; i < NPIX; i++) fpix[i] = 8'($urandom);
        run_frame("stall", 100, 2, 0);
        check("stall_seen", 32'(stall_done), 1);
        check("stall_hold", stall_bad, 0);

        // ack timeout with a silent transmitter
        bm_respond = 1'b0; cap.delete(); ndone = 0; pixq.delete(); stall_at = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("lat_pre_en", 32'(tx_en), 0);
        check("lat_pre_busy", 32'(frame_busy), 1);
        @(negedge clk);
        check("lat_en", 32'(tx_en), 1);
        check("lat_data", 32'(tx_data), 32'(S0));
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (k == TO - 1) check("to_early", 32'(err_timeout), 0);
            if (k == TO) begin
                check("to_set", 32'(err_timeout), 1);
                check("to_idle", 32'(frame_busy), 0);
            end
        end
        repeat (30) @(negedge clk);
        check("to_bytes", cap.size(), 1);
        check("to_ndone", ndone, 0);
        check("to_sticky", 32'(err_timeout), 1);
        bm_respond = 1'b1;
        for (int i = 0; i < NPIX; i++) fpix[i] = 8'($urandom);
        run_frame("after_to", 100, -1, 0);

        // reset while the first pixel byte is in WAIT_LO
        for (int i = 0; i < NPIX; i++) fpix[i] = 8'($urandom);
        cap.delete(); pixq.delete(); nsent = 0; valid_pct = 100; stall_at = -1;
        for (int i = 0; i < NPIX; i++) pixq.push_back(fpix[i]);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (cap.size() >= 7 && tx_busy) seen = 1;
        end
        check("rmid_reach", 32'(seen), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0; bm_kill = 1'b1;
        pixq.delete(); pend = 0;
        #1;
        check_zero("rmid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bm_kill = 1'b0;
        for (int i = 0; i < NPIX; i++) fpix[i] = 8'($urandom);
        run_frame("after_rst", 100, -1, 0);

        check("en_width", en_bad, 0);
        check("data_hold", data_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_sched.md
# uart_frame_sched

Frame scheduler that sequences the shared `uart_send` transmitter for one image frame. It emits a fixed header, pulls `IMG_W*IMG_H` grey pixels from the pixel source over a valid/ready handshake, then sends an 8-bit checksum. It sits between `RGB2Gray` and `uart_send` in place of the direct `send_en`/`img_gray` connection, and owns every `uart_en` pulse.

## Interface
- `IMG_W`, default 64: pixels per line, 1..65535.
- `IMG_H`, default 64: lines per frame, 1..65535.
- `SYNC0`, default 8'hAA: first header byte.
- `SYNC1`, default 8'h55: second header byte.
- `ACK_TIMEOUT`, default 16: maximum cycles to wait for `tx_busy` to rise after a `tx_en` pulse (≥4).
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to send a frame; sampled only in IDLE.
- `pix_valid`  in  1  source has a pixel on `pix_data`.
- `pix_data`  in  8  grey pixel value.
- `pix_ready`  out  1  scheduler accepts a pixel; transfer when `pix_valid && pix_ready`.
- `tx_busy`  in  1  `uart_send` busy flag.
- `tx_en`  out  1  one-cycle send strobe to `uart_send`.
- `tx_data`  out  8  byte to send; held stable from the `tx_en` cycle until `tx_busy` falls.
- `frame_busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse after the checksum byte completes.
- `err_timeout`  out  1  sticky; set on an ack timeout and cleared by the next accepted `start`.

## Operation
- Byte order: SYNC0, SYNC1, W[15:8], W[7:0], H[15:8], H[7:0], then `IMG_W*IMG_H` pixels in arrival order, then CKSUM.
- CKSUM is the sum of the pixel bytes only, modulo 256, in an 8-bit accumulator with no saturation. It clears on an accepted `start`.
- States:
  - IDLE: on `start`, go to LOAD with header index 0.
  - FETCH: `pix_ready`=1. On transfer, latch the pixel and add it to CKSUM, then go to LOAD.
  - LOAD: drive `tx_data` and pulse `tx_en`, then go to WAIT_HI.
  - WAIT_HI: wait for `tx_busy`=1, then go to WAIT_LO. If `ACK_TIMEOUT` cycles pass without it, set `err_timeout` and go to IDLE with no `frame_done`.
  - WAIT_LO: wait for `tx_busy`=0, then select the next source:
    - header index below 5: header index +1, go to LOAD;
    - pixels remaining: go to FETCH;
    - pixels done and CKSUM not yet sent: go to LOAD with CKSUM;
    - otherwise: go to DONE.
  - DONE: pulse `frame_done` for one cycle, then go to IDLE.
- Pixel counter width is `$clog2(IMG_W*IMG_H+1)`. It counts pixels transferred. The pixel phase ends when the count equals `IMG_W*IMG_H`; the counter never wraps.
- `pix_ready` is asserted only in FETCH, so at most one pixel is outstanding. A stalled `pix_valid` holds FETCH indefinitely with no timeout.
- `start` outside IDLE is ignored.
- `tx_busy` already high on entry to WAIT_HI counts as the ack.

## Timing
- Reset values: state IDLE; all outputs 0, including `tx_data`=8'h00. Counters and CKSUM are 0.
- Reset mid-frame: all state clears immediately. `tx_en` drops asynchronously, and the byte in flight in `uart_send` is not tracked.
- `start` sampled high at edge N gives `tx_en`=1 with `tx_data`=SYNC0 in the cycle after edge N+1 (LOAD).
- `tx_en` is high for exactly one cycle per byte.
- `tx_data` changes only in LOAD.
- Minimum spacing between two `tx_en` pulses is LOAD + 1 cycle in WAIT_HI + 1 cycle in WAIT_LO + FETCH (pixels only).
- Pixel transfer to `tx_en` for that pixel is 1 cycle.
- `frame_busy` falls in the same cycle the state returns to IDLE.
- `frame_done` and `frame_busy` are both high during DONE.

## Test plan
- Basic frame, `IMG_W`=`IMG_H`=2: pixels 10,20,30,40 (hex); busy model rises 3 cycles after `tx_en` and stays high for 20 cycles. Required `tx_data` sequence at `tx_en`: AA 55 00 02 00 02 10 20 30 40 A0; then `frame_done` pulses once; `err_timeout`=0.
- Checksum wrap, 2×2 frame: pixels FF FF FF FF -> CKSUM byte FC.
- Timeout: busy model never responds -> after SYNC0 `tx_en`, `err_timeout`=1 exactly `ACK_TIMEOUT` cycles later. State returns to IDLE, no further `tx_en`, no `frame_done`. The next `start` clears `err_timeout` and restarts at SYNC0.
- Source stall: withhold `pix_valid` for 50 cycles at pixel 2 -> `pix_ready` stays high, no `tx_en` during the stall, and the byte stream is unchanged afterwards.
- `start` pulsed during the pixel phase -> ignored; exactly one frame is produced.
- Reset mid-frame: drop `rst_n` for 1 cycle during WAIT_LO of pixel 1 -> all outputs go to 0 at once. A following `start` yields a complete, correct frame with CKSUM computed from fresh pixels only.
